// File: rtl/mux_pkg.sv
// mux_pkg: constants shared by the mux_scan slice.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input (also the two
//                             controller states)
//   MUX_N_DEFAULT           : default channel count
//   MUX_W_DEFAULT           : default data width per channel
package mux_pkg;

  localparam logic [0:0] MODE_MANUAL = 1'b0;
  localparam logic [0:0] MODE_SCAN   = 1'b1;

  localparam int MUX_N_DEFAULT = 8;
  localparam int MUX_W_DEFAULT = 1;

endpackage

// File: rtl/mux_scan_cnt.sv
// mux_scan_cnt: scan index counter for mux_scan.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (cnt -> 0)
//   clr : restart the scan; combined with inc the index lands on 1 because
//         channel 0 is being sampled in that same cycle
//   inc : advance the index by one, modulo N
//   cnt : current scan index (SW bits)
//   tc  : terminal count, high while cnt == N-1
module mux_scan_cnt #(
  parameter int N  = mux_pkg::MUX_N_DEFAULT,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [SW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == SW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? SW'(1) : '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + SW'(1);
    end
  end

endmodule

// File: rtl/mux_scan.sv
// mux_scan: registered N-to-1 channel multiplexer with manual select and
// auto-scan modes.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, highest priority
//   d     : flattened channel data, channel k at d[k*W +: W]
//   sel   : channel index used in manual mode
//   mode  : 0 manual select, 1 auto-scan
//   en    : sample enable
//   hold  : freeze scan index and outputs (wins over en)
//   y     : registered selected data
//   ch    : index of the channel presented on y
//   valid : y/ch were loaded on the previous edge
//   wrap  : auto-scan sample of channel N-1 is being presented
//   par   : XOR of y bits (only with MUX_SCAN_PARITY_EN defined)
//
// State | meaning
// ------+---------------------------------------------------
// MANUAL| mode_q == MODE_MANUAL: last non-held cycle was manual
// SCAN  | mode_q == MODE_SCAN  : last non-held cycle was auto-scan
// A MANUAL -> SCAN transition restarts the scan at channel 0.
module mux_scan
  import mux_pkg::*;
#(
  parameter int N  = MUX_N_DEFAULT,
  parameter int W  = MUX_W_DEFAULT,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  input  logic           hold,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic           par,
`endif
  output logic           wrap
);

  logic          mode_q;
  logic          scan;
  logic          start;
  logic          take;
  logic [SW-1:0] cnt;
  logic          tc;
  logic [SW-1:0] idx;
  logic [W-1:0]  dsel;

  assign scan  = (mode == MODE_SCAN);
  // mode_q freezes under hold, so a rise seen during hold still restarts
  // the scan on the first non-held cycle.
  assign start = scan && (mode_q == MODE_MANUAL) && !hold;
  assign take  = en && !hold;

  mux_scan_cnt #(.N(N), .SW(SW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (scan && take),
    .cnt (cnt),
    .tc  (tc)
  );

  always_comb begin
    idx = sel;
    if (scan) idx = start ? '0 : cnt;
    dsel = d[int'(idx)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_MANUAL;
    end else if (!hold) begin
      mode_q <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (take) begin
      y     <= dsel;
      ch    <= idx;
      valid <= 1'b1;
      // start implies channel 0 is sampled, which can never be N-1
      wrap  <= scan && !start && tc;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (take) begin
      par <= ^dsel;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT, N=8 W=4
  logic          rst, mode, en, hold;
  logic [N*W-1:0] d;
  logic [SW-1:0] sel;
  logic [W-1:0]  y;
  logic [SW-1:0] ch;
  logic          valid, wrap;
`ifdef MUX_SCAN_PARITY_EN
  logic          par;
`endif

  mux_scan #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .mode(mode), .en(en),
    .hold(hold), .y(y), .ch(ch), .valid(valid),
`ifdef MUX_SCAN_PARITY_EN
    .par(par),
`endif
    .wrap(wrap)
  );

  // second DUT, N=8 W=1, for the exhaustive manual check
  logic          rst1;
  logic [7:0]    d1;
  logic [SW-1:0] sel1;
  logic [0:0]    y1;
  logic [SW-1:0] ch1;
  logic          valid1, wrap1;
`ifdef MUX_SCAN_PARITY_EN
  logic          par1;
`endif

  mux_scan #(.N(8), .W(1)) dut1 (
    .clk(clk), .rst(rst1), .d(d1), .sel(sel1), .mode(1'b0), .en(1'b1),
    .hold(1'b0), .y(y1), .ch(ch1), .valid(valid1),
`ifdef MUX_SCAN_PARITY_EN
    .par(par1),
`endif
    .wrap(wrap1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: expected outputs plus the next channel the scan visits
  int m_y, m_ch, m_valid, m_wrap, m_par;
  int m_pos;
  bit m_auto;

  function automatic int chan(int k);
    return int'(d[k*W +: W]);
  endfunction

  function automatic int xor_bits(int v);
    int p = 0;
    for (int b = 0; b < W; b++) p ^= (v >> b) & 1;
    return p;
  endfunction

  task automatic model_update();
    int k;
    if (rst) begin
      m_y = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_par = 0;
      m_pos = 0; m_auto = 0;
      return;
    end
    if (hold) begin
      m_valid = 0; m_wrap = 0;
      return;
    end
    if (mode && !m_auto) m_pos = 0;
    m_auto = mode;
    if (!en) begin
      m_valid = 0; m_wrap = 0;
      return;
    end
    if (mode) begin
      k = m_pos;
      m_pos = (m_pos + 1) % N;
      m_wrap = (k == N - 1);
    end else begin
      k = int'(sel);
      m_wrap = 0;
    end
    m_y = chan(k); m_ch = k; m_valid = 1; m_par = xor_bits(m_y);
  endtask

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".y"},     int'(y),     m_y);
    chk({tag, ".ch"},    int'(ch),    m_ch);
    chk({tag, ".valid"}, int'(valid), m_valid);
    chk({tag, ".wrap"},  int'(wrap),  m_wrap);
`ifdef MUX_SCAN_PARITY_EN
    chk({tag, ".par"},   int'(par),   m_par);
`endif
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1; mode = 0; en = 0; hold = 0; sel = '0;
    rst1 = 1; d1 = '0; sel1 = '0;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 1);
    m_y = -1; m_ch = -1; m_valid = -1; m_wrap = -1; m_par = -1;
    m_pos = 0; m_auto = 0;

    // reset state, with explicit constants
    step("reset");
    chk("reset.y0", int'(y), 0);
    chk("reset.valid0", int'(valid), 0);
    rst = 0; rst1 = 0;

    // manual select, channel k holds k+1
    mode = 0; en = 1;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      step("manual");
      chk("manual.y_const", int'(y), s + 1);
    end

    // auto scan, 10 cycles: 0..7,0,1 with wrap only on ch 7
    mode = 1;
    for (int i = 0; i < 10; i++) begin
      step("auto");
      chk("auto.ch_const", int'(ch), i % N);
      chk("auto.wrap_const", int'(wrap), (i % N == N - 1) ? 1 : 0);
    end

    // hold priority: scan to ch 3, hold 3 cycles, then continue at 4
    mode = 0; step("hold.pre");
    mode = 1;
    for (int i = 0; i < 4; i++) step("hold.scan");
    chk("hold.at3", int'(ch), 3);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      step("hold.frozen");
      chk("hold.ch_const", int'(ch), 3);
      chk("hold.valid_const", int'(valid), 0);
    end
    hold = 0;
    step("hold.release");
    chk("hold.next4", int'(ch), 4);

    // mode switch: manual sel=5 twice, then auto starts at 0
    mode = 0; sel = 3'd5;
    step("switch.man"); step("switch.man");
    mode = 1;
    step("switch.auto");
    chk("switch.ch0", int'(ch), 0);

    // reset mid-scan at ch 6
    for (int i = 0; i < 6; i++) step("midrst.scan");
    chk("midrst.at6", int'(ch), 6);
    rst = 1;
    step("midrst.rst");
    chk("midrst.ch0", int'(ch), 0);
    rst = 0;
    step("midrst.restart");
    chk("midrst.restart0", int'(ch), 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      mode = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 39) == 0);
      sel  = SW'($urandom_range(0, N - 1));
      d    = {$urandom(), $urandom()} >> 32;
      step("random");
    end
    rst = 0; hold = 0;

`ifdef MUX_SCAN_PARITY_EN
    // parity: channel 2 = 4'b0111 selected manually
    d[2*W +: W] = 4'b0111; mode = 0; en = 1; sel = 3'd2;
    step("parity");
    chk("parity.one", int'(par), 1);
`endif

    // exhaustive 8x1 manual check on the W=1 instance
    for (int s = 0; s < 8; s++) begin
      for (int v = 0; v < 256; v++) begin
        sel1 = SW'(s); d1 = 8'(v);
        @(posedge clk); #1;
        chk("exh8x1.y", int'(y1), (v >> s) & 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
- REQ-001 SHALL have parameter N, default 8, meaning number of input channels (power of 2, at least 2).
- REQ-002 SHALL have parameter W, default 1, meaning data width per channel.
- REQ-003 SHALL define localparam SW = $clog2(N), the channel index width.
- REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-006 SHALL have port d, input, N*W bits: flattened channel data, channel k at bits [k*W +: W].
- REQ-007 SHALL have port sel, input, SW bits: channel index used in manual mode.
- REQ-008 SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
- REQ-009 SHALL have port en, input, 1 bit: sample enable.
- REQ-010 SHALL have port hold, input, 1 bit: freeze the scan counter and outputs.
- REQ-011 SHALL have port y, output, W bits: registered selected data.
- REQ-012 SHALL have port ch, output, SW bits: index of the channel currently presented on y.
- REQ-013 SHALL have port valid, output, 1 bit: y/ch updated on the previous edge.
- REQ-014 SHALL have port wrap, output, 1 bit: one-cycle pulse when an auto-scan sample of channel N-1 is presented.

Function
- REQ-015 SHALL register all outputs, with 1-cycle latency from the sampling edge to y/ch/valid.
- REQ-016 SHALL, in manual mode with en=1 and hold=0, load y <= d[sel] and ch <= sel, and set valid to 1.
- REQ-017 SHALL, in auto mode with en=1 and hold=0, load y <= d[cnt] and ch <= cnt, set valid to 1, and advance cnt to cnt+1 modulo N.
- REQ-018 SHALL set wrap to 1 for exactly the cycle in which ch=N-1 was loaded in auto mode, and to 0 otherwise.
- REQ-019 SHALL, when en=0 and hold=0, keep y/ch and drive valid=0 and wrap=0.
- REQ-020 SHALL give hold priority over en: with hold=1, cnt/y/ch are frozen and valid=0, wrap=0.
- REQ-021 SHALL keep a registered copy mode_q; on a cycle where mode=1 and mode_q=0, the scan SHALL start at channel 0 regardless of the previous cnt value.
- REQ-022 SHALL leave cnt unchanged while in manual mode.
- REQ-023 SHALL have exactly two states, MANUAL and SCAN, selected by mode each cycle, with no other states.

Reset
- REQ-024 SHALL give rst priority over all other inputs.
- REQ-025 SHALL, on a cycle with rst=1, clear y=0, ch=0, valid=0, wrap=0, cnt=0 and mode_q=0.
- REQ-026 SHALL, on a reset asserted mid-scan, restart auto scan at channel 0 on the first enabled cycle after release.

Configuration
- REQ-027 SHALL, with macro MUX_SCAN_PARITY_EN defined, add output par (1 bit), registered alongside y, equal to the XOR of the loaded W bits, reset to 0, and held when y holds.
- REQ-028 SHALL, without MUX_SCAN_PARITY_EN, have no par port and be otherwise identical.

Structure
- REQ-029 SHALL put the mode encodings (MODE_MANUAL=0, MODE_SCAN=1) and the default N/W constants in shared package mux_pkg.
- REQ-030 SHALL implement the scan index as sub-module mux_scan_cnt (parameter N; inputs clk, rst, clr, inc; output cnt, SW bits; terminal-count flag).
- REQ-031 SHALL keep the data-select logic combinational inside mux_scan.

Verification (N=8, W=4 unless noted)
- REQ-032 SHALL cover manual mode: d = channel k holds value k+1, mode=0, en=1, sel stepped 0..7 -> one cycle later y=1..8, ch=sel, valid=1 each cycle.
- REQ-033 SHALL cover auto mode: same d, mode=1, en=1 for 10 cycles -> ch sequence 0,1,...,7,0,1; wrap=1 only when ch=7.
- REQ-034 SHALL cover hold priority: auto scan at ch=3, hold=1 and en=1 for 3 cycles -> y/ch stay at channel 3, valid=0; after hold release the next ch is 4.
- REQ-035 SHALL cover a mode switch: manual sel=5 for 2 cycles, then mode=1 -> the first auto sample presents ch=0.
- REQ-036 SHALL cover reset mid-scan: rst=1 at ch=6 -> next cycle y=0, ch=0, valid=0, wrap=0; after release, auto restarts at ch=0.
- REQ-037 SHALL cover the exhaustive 8x1 check with N=8, W=1: all 2048 combinations of {sel, d} in manual mode -> y equals d[sel] one cycle later; with MUX_SCAN_PARITY_EN defined and W=4, d[2]=4'b0111 selected -> par=1.
